// File: rtl/cic_int_2.sv
// -----------------------------------------------------------------------------
// cic_int_2 -- CIC interpolator (comb section at the low rate, zero stuffing,
// integrator section at the clk rate).
//
// The block paces its own input: it raises req for one clk every RATE clks, and
// x is captured on the edge that ends that req cycle. The samples then pass
// through NUM_STAGES comb stages, each one clocked forward by a one-hot enable
// pipeline. The comb output is zero-stuffed and fed into a cascade of
// NUM_STAGES integrators that run every clk. The DC gain is
// RATE^(NUM_STAGES-1). The block does not normalise the gain.
//
// Parameters
//   NUM_STAGES : number of comb and integrator stages
//   RATE       : interpolation ratio (2..256)
//   STG_GSZ    : bit growth per stage, at least ceil(log2(RATE))
//   ISZ        : input word size
//   OSZ        : internal and output word size
//
// Ports
//   clk   : in  1       rising-edge clock, single domain
//   reset : in  1       asynchronous active-low reset
//   x     : in  ISZ     signed low-rate input sample, captured when req=1
//   req   : out 1       one-clk request pulse, once every RATE clks
//   y     : out OSZ     signed high-rate output sample, one per clk
//   valid : out 1       y carries filter data (sticky until reset)
// -----------------------------------------------------------------------------
module cic_int_2 #(
    parameter int NUM_STAGES = 4,
    parameter int RATE       = 8,
    parameter int STG_GSZ    = 3,
    parameter int ISZ        = 10,
    parameter int OSZ        = ISZ + NUM_STAGES * STG_GSZ
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [ISZ-1:0] x,
    output logic                  req,
    output logic signed [OSZ-1:0] y,
    output logic                  valid
);

    localparam int               CNT_W   = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE - 1);

    // Rate counter and request pulse
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_q, req_d;

    // One-hot enable pipeline. Bit k marks the sample currently in comb stage k.
    logic [NUM_STAGES:0]     ena_q, ena_d;

    // Comb section. diff[k] is the output of stage k, and dly[k] holds the
    // previous sample's diff[k]. The last stage has no consumer for its delay.
    logic signed [OSZ-1:0]   diff_q [0:NUM_STAGES];
    logic signed [OSZ-1:0]   diff_d [0:NUM_STAGES];
    logic signed [OSZ-1:0]   dly_q  [0:NUM_STAGES-1];
    logic signed [OSZ-1:0]   dly_d  [0:NUM_STAGES-1];

    // Integrator section
    logic signed [OSZ-1:0]   integ_q [0:NUM_STAGES-1];
    logic signed [OSZ-1:0]   integ_d [0:NUM_STAGES-1];

    // Output registers
    logic signed [OSZ-1:0]   y_q, y_d;
    logic                    valid_q, valid_d;

    // Combinational helpers
    logic signed [OSZ-1:0]   x_sx_s;
    logic signed [OSZ-1:0]   stuff_s;

    // Rate counter wrap, request generation and enable pipeline shift
    always_comb begin
        cnt_d = cnt_q;
        req_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            req_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            req_d = 1'b0;
        end
        ena_d = {ena_q[NUM_STAGES-1:0], req_q};
    end

    // Comb section: stage 0 loads the sign-extended input, and later stages
    // take the difference when their enable bit arrives
    always_comb begin
        x_sx_s = {{(OSZ-ISZ){x[ISZ-1]}}, x};
        for (int j = 0; j <= NUM_STAGES; j++) begin
            diff_d[j] = diff_q[j];
        end
        for (int j = 0; j < NUM_STAGES; j++) begin
            dly_d[j] = dly_q[j];
        end

        // x is ignored outside the request cycle
        if (req_q) begin
            diff_d[0] = x_sx_s;
            dly_d[0]  = diff_q[0];
        end else begin
            diff_d[0] = diff_q[0];
            dly_d[0]  = dly_q[0];
        end

        for (int j = 1; j <= NUM_STAGES; j++) begin
            if (ena_q[j-1]) begin
                diff_d[j] = diff_q[j-1] - dly_q[j-1];
            end else begin
                diff_d[j] = diff_q[j];
            end
        end
        for (int j = 1; j < NUM_STAGES; j++) begin
            if (ena_q[j-1]) begin
                dly_d[j] = diff_q[j];
            end else begin
                dly_d[j] = dly_q[j];
            end
        end
    end

    // Zero stuffing and integrator cascade. Modular wrap is intentional
    // because the comb section cancels the integrator overflow.
    always_comb begin
        if (ena_q[NUM_STAGES]) begin
            stuff_s = diff_q[NUM_STAGES];
        end else begin
            stuff_s = '0;
        end
        integ_d[0] = integ_q[0] + stuff_s;
        for (int i = 1; i < NUM_STAGES; i++) begin
            integ_d[i] = integ_q[i] + integ_q[i-1];
        end
        y_d     = integ_q[NUM_STAGES-1];
        valid_d = valid_q | ena_q[NUM_STAGES];
    end

    // State register for the whole pipeline, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            ena_q   <= '0;
            for (int j = 0; j <= NUM_STAGES; j++) begin
                diff_q[j] <= '0;
            end
            for (int j = 0; j < NUM_STAGES; j++) begin
                dly_q[j]   <= '0;
                integ_q[j] <= '0;
            end
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ena_q   <= ena_d;
            for (int j = 0; j <= NUM_STAGES; j++) begin
                diff_q[j] <= diff_d[j];
            end
            for (int j = 0; j < NUM_STAGES; j++) begin
                dly_q[j]   <= dly_d[j];
                integ_q[j] <= integ_d[j];
            end
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign req   = req_q;
    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_cic_int_2.sv
// -----------------------------------------------------------------------------
// tb_cic_int_2 -- directed bench for cic_int_2.
// Instance u_dut uses the default parameters. Instance u_dut2 uses
// NUM_STAGES=1 and RATE=4 for the single-step hold check.
// -----------------------------------------------------------------------------
module tb_cic_int_2;

    localparam int OSZ1 = 22;
    localparam int OSZ2 = 12;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   reset2;
    logic signed [9:0]      x;
    logic signed [9:0]      x2;
    logic                   req, req2;
    logic                   valid, valid2;
    logic signed [OSZ1-1:0] y;
    logic signed [OSZ2-1:0] y2;

    int n_vec = 0;
    int n_err = 0;

    // Expected values for clk c after reset release (index c-1), with default
    // parameters and constant x. y = ycoef * x. The first sample reaches y on
    // clk 18, and the second sample's comb output (-3x) arrives from clk 22.
    typedef struct {
        int   cyc;
        logic req;
        logic valid;
        int   ycoef;
    } vec_t;
    vec_t vtab [0:24];

    always #5 clk = ~clk;

    cic_int_2 u_dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .req   (req),
        .y     (y),
        .valid (valid)
    );

    cic_int_2 #(
        .NUM_STAGES (1),
        .RATE       (4),
        .STG_GSZ    (2),
        .ISZ        (10)
    ) u_dut2 (
        .clk   (clk),
        .reset (reset2),
        .x     (x2),
        .req   (req2),
        .y     (y2),
        .valid (valid2)
    );

    task automatic check(input string name, input int cyc,
                         input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s clk=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Pulse reset for one clk and check that the outputs clear at once
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, "_rst_y"}, 0, y, 0);
        check({tag, "_rst_req"}, 0, {31'd0, req}, 0);
        check({tag, "_rst_valid"}, 0, {31'd0, valid}, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Run ncyc clks from reset release with x=val on request cycles.
    // When garbage is set, the other cycles get random x.
    task automatic run_seq(input int val, input bit garbage, input int ncyc, input string tag);
        x = 10'(val);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c <= 25) begin
                check({tag, "_req"}, c, {31'd0, req}, {31'd0, vtab[c-1].req});
                check({tag, "_valid"}, c, {31'd0, valid}, {31'd0, vtab[c-1].valid});
                check({tag, "_y"}, c, y, vtab[c-1].ycoef * val);
            end
            if (c >= 80) begin
                check({tag, "_settled"}, c, y, val * 512);
            end
            if (garbage && (c % 8) != 0) begin
                x = 10'($urandom_range(0, 1023));
            end else begin
                x = 10'(val);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 25; i++) begin
            vtab[i].cyc   = i + 1;
            vtab[i].req   = ((i + 1) % 8 == 0);
            vtab[i].valid = (i + 1 >= 14);
            vtab[i].ycoef = 0;
        end
        vtab[17].ycoef = 1;
        vtab[18].ycoef = 4;
        vtab[19].ycoef = 10;
        vtab[20].ycoef = 20;
        vtab[21].ycoef = 35;
        vtab[22].ycoef = 56;
        vtab[23].ycoef = 84;
        vtab[24].ycoef = 120;

        reset  = 1'b0;
        reset2 = 1'b0;
        x      = 10'sd100;
        x2     = 10'sd1;

        // Power-up reset state
        @(negedge clk);
        @(negedge clk);
        check("init_y", 0, y, 0);
        check("init_req", 0, {31'd0, req}, 0);
        check("init_valid", 0, {31'd0, valid}, 0);
        reset = 1'b1;

        // Constant x=100, settling to 100*8^3
        run_seq(100, 1'b0, 111, "dc100");

        // Constant x=-512, settling to -262144 without wrap artefacts
        pulse_reset("a");
        run_seq(-512, 1'b0, 111, "dcm512");

        // x is disturbed only outside request cycles, so the output must
        // match the clean x=100 sequence
        pulse_reset("b");
        run_seq(100, 1'b1, 111, "ign");

        // Reset in the middle of the stream, then a bit-exact restart
        pulse_reset("c");
        run_seq(100, 1'b0, 50, "pre");
        pulse_reset("mid");
        run_seq(100, 1'b0, 111, "restart");

        // NUM_STAGES=1, RATE=4: x=1 for one sample, then 0. y must step to 1
        // for clks 8..11 only.
        @(negedge clk);
        x2     = 10'sd1;
        reset2 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("s1_y", c, y2, ((c >= 8) && (c <= 11)) ? 1 : 0);
            check("s1_req", c, {31'd0, req2}, ((c % 4) == 0) ? 1 : 0);
            check("s1_valid", c, {31'd0, valid2}, (c >= 7) ? 1 : 0);
            if (c >= 5) begin
                x2 = 10'sd0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
